apb_cfg_sequencer: RTL

//  Upstream command sequencer for the DFE APB configuration wrapper. Accepts

---
 rtl/dfe_apb_pkg.sv | 19 +
 rtl/cfg_cmd_fifo.sv | 38 +++
 rtl/apb_cfg_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/dfe_apb_pkg.sv
// dfe_apb_pkg: shared command type, FSM states and component indices for the APB config sequencer
package dfe_apb_pkg;
  localparam int CMD_ADDR_W = 7;
  localparam int CMD_DATA_W = 20;
  localparam int CMD_COMP = 5;
  localparam int CMD_SEL_W = $clog2(CMD_COMP);
  localparam logic [CMD_SEL_W-1:0] SEL_FRAC_DECI = CMD_SEL_W'(0);
  localparam logic [CMD_SEL_W-1:0] SEL_IIR = CMD_SEL_W'(1);
  localparam logic [CMD_SEL_W-1:0] SEL_CTRL = CMD_SEL_W'(2);
  localparam logic [CMD_SEL_W-1:0] SEL_CIC = CMD_SEL_W'(3);
  localparam logic [CMD_SEL_W-1:0] SEL_FIR = CMD_SEL_W'(4);
  typedef struct packed {
    logic write;
    logic [CMD_SEL_W-1:0] sel;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cfg_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} seq_state_t;
endpackage

// File: rtl/cfg_cmd_fifo.sv
// cfg_cmd_fifo: synchronous command FIFO with full/empty flags
module cfg_cmd_fifo
  import dfe_apb_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  cfg_cmd_t din,
  output cfg_cmd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  cfg_cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/apb_cfg_sequencer.sv
// apb_cfg_sequencer: buffers register commands and replays them one at a time as APB master transfers
module apb_cfg_sequencer
  import dfe_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = CMD_ADDR_W,
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = CMD_DATA_W,
  parameter int COMP        = CMD_COMP,
  parameter int FIFO_DEPTH  = 4,
  parameter int XFER_CYCLES = 3
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [$clog2(COMP)-1:0] cmd_sel,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [COEFF_WIDTH-1:0]  cmd_wdata,
  output logic                    MTRANS,
  output logic                    MWRITE,
  output logic [COMP-1:0]         MSELx,
  output logic [ADDR_WIDTH-1:0]   MADDR,
  output logic [COEFF_WIDTH-1:0]  MWDATA,
  input  logic [PDATA_WIDTH-1:0]  MRDATA,
  output logic                    rsp_valid,
  output logic [PDATA_WIDTH-1:0]  rsp_data,
  output logic                    busy,
  output logic                    err
);
  localparam int CW = $clog2(XFER_CYCLES);
  cfg_cmd_t cmd, head;
  seq_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic full, empty, pop, bad;
  assign cmd = '{write: cmd_write, sel: cmd_sel, addr: cmd_addr, wdata: cmd_wdata};
  assign pop = state == IDLE && !empty;
  assign bad = head.sel >= CMD_SEL_W'(COMP);
  assign cmd_ready = !full;
  assign busy = !empty || state != IDLE;
  cfg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .pop  (pop),
    .din  (cmd),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    state_n = state == IDLE ? (pop && !bad ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              cnt == '0 ? IDLE : WAIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      MTRANS <= 1'b0;
      MWRITE <= 1'b0;
      MSELx <= '0;
      MADDR <= '0;
      MWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      MTRANS <= pop && !bad;
      err <= pop && bad;
      rsp_valid <= 1'b0;
      if (pop && !bad) begin
        MWRITE <= head.write;
        MSELx <= COMP'(1) << head.sel;
        MADDR <= head.addr;
        MWDATA <= head.wdata;
      end
      if (state == ISSUE) cnt <= CW'(XFER_CYCLES - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) begin
        MSELx <= '0;
        if (!MWRITE) begin
          rsp_valid <= 1'b1;
          rsp_data <= MRDATA;
        end
      end
    end
endmodule
